mem_wb_regfile: RTL and testbench
=================================

// Module: mem_wb_regfile
// PURPOSE
//  Write-back stage of the 5-stage MIPS32 pipeline. Sits directly downstream of the MEM stage.
//  - Latches MEM's result (wd/wreg/wdata) in the MEM/WB pipeline register, honouring stall and flush.
//  - Commits that result into the 32x32 general-purpose register file.
//  - Serves ID's two read ports, with same-cycle write-through bypass from the write-back port.
// PARAMETERS
//  REG_NUM     32  number of GPRs; fixed, address width 5
//  DATA_W      32  GPR width
//  STALL_W      6  stall vector width; bit 4 = MEM stage, bit 5 = WB stage
// PORTS
//  clk         in   1   rising-edge clock
//  rst         in   1   reset rst, synchronous, active-high
//  stall       in   6   pipeline stall vector from ctrl
//  flush       in   1   exception flush; kills the MEM/WB latch
//  mem_wd      in   5   destination register from MEM
//  mem_wreg    in   1   write enable from MEM
//  mem_wdata   in  32   result data from MEM
//  re1         in   1   read-port-1 enable (ID)
//  raddr1      in   5   read-port-1 address
//  rdata1      out 32   read-port-1 data, combinational
//  re2         in   1   read-port-2 enable
//  raddr2      in   5   read-port-2 address
//  rdata2      out 32   read-port-2 data, combinational
//  wb_wd       out  5   latched write-back address (observability)
//  wb_wreg     out  1   latched write-back enable
//  wb_wdata    out 32   latched write-back data
//  retire_cnt  out 32   count of committed register writes
// BEHAVIOUR
//  - Reset (rst=1 at posedge):
//    - wb_wd=5'b0, wb_wreg=0, wb_wdata=0, retire_cnt=0, all 32 GPRs cleared to 0.
//    - rdata1/rdata2=0 while rst=1.
//  - Latch update at each posedge; priority order:
//    1. rst
//    2. flush: latch := {0,0,0} (bubble)
//    3. stall[4]=1 && stall[5]=0: insert bubble (latch := 0)
//    4. stall[4]=0: latch := mem_*
//    5. otherwise: hold
//  - Commit at each posedge:
//    - Condition: rst=0, stall[5]=0, wb_wreg=1.
//    - GPR[wb_wd] := wb_wdata, unless wb_wd=0 (write dropped).
//    - retire_cnt += 1, including r0 writes; wraps 2^32-1 -> 0.
//  - Latency: MEM result captured at edge N; visible on wb_* during cycle N+1; stored in array at edge N+1.
//    - ID reads in cycle N+1 obtain it via bypass; later reads obtain it from the array.
//  - Read port k (k=1,2), combinational, evaluated in order:
//    1. rst=1 or re_k=0: 0
//    2. raddr_k=0: 0
//    3. wb_wreg=1, !stall[5], raddr_k==wb_wd: wb_wdata (bypass)
//    4. else: GPR[raddr_k]
//  - Simultaneous events:
//    - flush in the same cycle as a commit: the commit of the current latch still happens; only the next latch is killed.
//    - Both ports reading the same address: identical data.
//  - Reset mid-stall or mid-flush: rst wins; no commit that edge.
//  - No X propagation: every output is defined from the first post-reset cycle.
// STRUCTURE
//  - Shared package/defines (existing defines file): RstEnable, WriteEnable/Disable, ReadEnable/Disable,
//    ZeroWord, NOPRegAddr, RegAddrBus, RegBus, RegNum, stall bit indices.
//  - One natural sub-module: regfile (array, commit logic, two bypassed read ports).
//  - The top holds the MEM/WB latch and retire_cnt, and instantiates regfile.
// TESTING
//  1. Reset: rst=1 for 2 cycles with mem_wreg=1 -> wb_* all 0, retire_cnt=0, rdata1=rdata2=0.
//  2. Write/readback: mem_wd=3, wreg=1, wdata=32'hDEADBEEF.
//     - Next cycle, raddr1=3, re1=1 -> rdata1=DEADBEEF via bypass.
//     - Two cycles later, same value from the array; retire_cnt=1.
//  3. r0 guard: write 32'h1234 to r0 -> raddr2=0 reads 0 in every cycle; retire_cnt increments.
//  4. Stall/bubble:
//     - stall=6'b010000 with mem_wd=5, wdata=7 -> wb_wreg=0 next cycle; no commit.
//     - stall=6'b110000 -> latch holds; retire_cnt unchanged.
//  5. Flush: flush=1 while MEM presents a write to r8 -> r8 unchanged; the prior latched write to r9 still commits.
//  6. Counter wrap: force retire_cnt=32'hFFFFFFFF, one commit -> retire_cnt=0.

Source files
------------

// File: rtl/mem_wb_regfile_pkg.sv
// Shared definitions for the MIPS32 write-back stage: bus widths, enable
// encodings, stall-vector bit positions and the MEM/WB latch layout.
package mem_wb_regfile_pkg;

    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int STALL_W    = 6;

    // Stall vector bit positions
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic RstEnable    = 1'b1;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;
    localparam logic ReadEnable   = 1'b1;
    localparam logic ReadDisable  = 1'b0;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_t;

    localparam reg_t      ZeroWord   = '0;
    localparam reg_addr_t NOPRegAddr = '0;

    // Contents of the MEM/WB pipeline register
    typedef struct packed {
        reg_addr_t wd;
        logic      wreg;
        reg_t      wdata;
    } wb_latch_t;

    localparam wb_latch_t WB_BUBBLE = '{wd: NOPRegAddr, wreg: WriteDisable, wdata: ZeroWord};

    // One GPR read port: disabled/reset and r0 read as zero, a matching
    // in-flight commit is forwarded, otherwise the stored value is returned.
    function automatic reg_t read_port(
        input logic      rst,
        input logic      re,
        input reg_addr_t raddr,
        input logic      commit,
        input reg_addr_t waddr,
        input reg_t      wdata,
        input reg_t      stored
    );
        reg_t result;
        if (rst == RstEnable || re == ReadDisable) begin
            result = ZeroWord;
        end else if (raddr == NOPRegAddr) begin
            result = ZeroWord;
        end else if (commit && raddr == waddr) begin
            result = wdata;
        end else begin
            result = stored;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_wb_regfile_regfile.sv
// 32x32 general-purpose register file with one write port (fed by the
// MEM/WB latch) and two combinational read ports with write-through bypass.
module mem_wb_regfile_regfile
    import mem_wb_regfile_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      commit_i,
    input  reg_addr_t waddr_i,
    input  reg_t      wdata_i,
    input  logic      re1_i,
    input  reg_addr_t raddr1_i,
    output reg_t      rdata1_o,
    input  logic      re2_i,
    input  reg_addr_t raddr2_i,
    output reg_t      rdata2_o
);

    reg_t gpr_q [REG_NUM];

    genvar gi;
    generate
        for (gi = 0; gi < REG_NUM; gi++) begin : g_gpr
            if (gi == 0) begin : g_zero
                // r0 is hard-wired to zero; writes to it are simply dropped
                assign gpr_q[gi] = ZeroWord;
            end else begin : g_reg
                // Clear on reset, otherwise take the committed value when addressed
                always_ff @(posedge clk) begin
                    if (rst == RstEnable) begin
                        gpr_q[gi] <= ZeroWord;
                    end else if (commit_i && waddr_i == REG_ADDR_W'(gi)) begin
                        gpr_q[gi] <= wdata_i;
                    end
                end
            end
        end
    endgenerate

    // Both read ports resolve reset, r0, bypass and array lookup in priority order
    always_comb begin
        rdata1_o = read_port(rst, re1_i, raddr1_i, commit_i, waddr_i, wdata_i, gpr_q[raddr1_i]);
        rdata2_o = read_port(rst, re2_i, raddr2_i, commit_i, waddr_i, wdata_i, gpr_q[raddr2_i]);
    end

endmodule

// File: rtl/mem_wb_regfile.sv
// Write-back stage: MEM/WB pipeline register with stall/flush handling,
// retired-write counter, and the GPR file that the latched result commits into.
module mem_wb_regfile
    import mem_wb_regfile_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [4:0]         mem_wd,
    input  logic               mem_wreg,
    input  logic [31:0]        mem_wdata,
    input  logic               re1,
    input  logic [4:0]         raddr1,
    output logic [31:0]        rdata1,
    input  logic               re2,
    input  logic [4:0]         raddr2,
    output logic [31:0]        rdata2,
    output logic [4:0]         wb_wd,
    output logic               wb_wreg,
    output logic [31:0]        wb_wdata,
    output logic [31:0]        retire_cnt
);

    wb_latch_t latch_q, latch_d;
    reg_t      retire_cnt_q, retire_cnt_d;
    logic      commit;
    logic      unused_stall;

    // Only the MEM and WB stall bits matter to this stage
    assign unused_stall = ^stall[STALL_MEM-1:0];

    // A commit needs a valid latched write and an unstalled WB stage; it
    // happens even when flush kills the next latch value.
    assign commit = (rst != RstEnable) && latch_q.wreg && !stall[STALL_WB];

    // Next latch value: flush, then MEM-stalled bubble, then advance, else hold
    always_comb begin
        latch_d = latch_q;
        if (flush) begin
            latch_d = WB_BUBBLE;
        end else if (stall[STALL_MEM] && !stall[STALL_WB]) begin
            latch_d = WB_BUBBLE;
        end else if (!stall[STALL_MEM]) begin
            latch_d = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata};
        end
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            latch_q <= WB_BUBBLE;
        end else begin
            latch_q <= latch_d;
        end
    end

    // Count every commit, including dropped r0 writes; wraps naturally
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (commit) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    // Retired-write counter register
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            retire_cnt_q <= ZeroWord;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    mem_wb_regfile_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .commit_i (commit),
        .waddr_i  (latch_q.wd),
        .wdata_i  (latch_q.wdata),
        .re1_i    (re1),
        .raddr1_i (raddr1),
        .rdata1_o (rdata1),
        .re2_i    (re2),
        .raddr2_i (raddr2),
        .rdata2_o (rdata2)
    );

    assign wb_wd      = latch_q.wd;
    assign wb_wreg    = latch_q.wreg;
    assign wb_wdata   = latch_q.wdata;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_mem_wb_regfile.sv
// Directed bench for the write-back stage. Stimulus drives inputs just after
// each rising edge and queues the values expected in that cycle; a monitor
// on the falling edge drains the queue and compares against the DUT.
module tb_mem_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic [31:0] retire_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int S_RD1 = 0, S_RD2 = 1, S_WD = 2, S_WREG = 3, S_WDATA = 4, S_CNT = 5;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    mem_wb_regfile dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .mem_wd     (mem_wd),
        .mem_wreg   (mem_wreg),
        .mem_wdata  (mem_wdata),
        .re1        (re1),
        .raddr1     (raddr1),
        .rdata1     (rdata1),
        .re2        (re2),
        .raddr2     (raddr2),
        .rdata2     (rdata2),
        .wb_wd      (wb_wd),
        .wb_wreg    (wb_wreg),
        .wb_wdata   (wb_wdata),
        .retire_cnt (retire_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.sig  = sig;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic mem(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata);
        mem_wd    = wd;
        mem_wreg  = wreg;
        mem_wdata = wdata;
    endtask

    task automatic expect_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata, input string tag);
        expect_val(S_WD,    32'(wd),   {tag, "_wb_wd"});
        expect_val(S_WREG,  32'(wreg), {tag, "_wb_wreg"});
        expect_val(S_WDATA, wdata,     {tag, "_wb_wdata"});
    endtask

    // Monitor: compare every expectation queued for the current cycle
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t        e;
            logic [31:0] act;
            e = exp_q.pop_front();
            case (e.sig)
                S_RD1:   act = rdata1;
                S_RD2:   act = rdata2;
                S_WD:    act = 32'(wb_wd);
                S_WREG:  act = 32'(wb_wreg);
                S_WDATA: act = wb_wdata;
                default: act = retire_cnt;
            endcase
            n_checks++;
            if (act === e.val) begin
                n_pass++;
                $display("check %s ok: %h", e.name, act);
            end else begin
                $display("FAIL %s: got %h expected %h", e.name, act, e.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; stall = 6'b0; flush = 1'b0;
        mem(5'd7, 1'b1, 32'd55);
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;

        // 1. Reset held for two edges with a write pending on MEM
        step();
        expect_wb(5'd0, 1'b0, 32'd0, "rst1");
        expect_val(S_CNT, 32'd0, "rst1_cnt");
        expect_val(S_RD1, 32'd0, "rst1_rd1");
        expect_val(S_RD2, 32'd0, "rst1_rd2");
        step();
        expect_wb(5'd0, 1'b0, 32'd0, "rst2");
        expect_val(S_CNT, 32'd0, "rst2_cnt");
        rst = 1'b0;
        mem_wreg = 1'b0;
        expect_val(S_RD1, 32'd0, "rst_out_rd1");

        // 2. Write r3 and read it back via bypass, then from the array
        step();
        mem(5'd3, 1'b1, 32'hDEADBEEF);
        raddr1 = 5'd3;
        expect_val(S_WREG, 32'd0, "wr_pre_wreg");
        step();
        mem_wreg = 1'b0;
        expect_wb(5'd3, 1'b1, 32'hDEADBEEF, "wr_lat");
        expect_val(S_RD1, 32'hDEADBEEF, "wr_bypass_rd1");
        expect_val(S_CNT, 32'd0, "wr_lat_cnt");
        step();
        expect_val(S_WREG, 32'd0, "wr_post_wreg");
        expect_val(S_RD1, 32'hDEADBEEF, "wr_array_rd1");
        expect_val(S_CNT, 32'd1, "wr_cnt");
        step();
        raddr2 = 5'd3;
        expect_val(S_RD1, 32'hDEADBEEF, "same_addr_rd1");
        expect_val(S_RD2, 32'hDEADBEEF, "same_addr_rd2");
        step();
        re1 = 1'b0;
        expect_val(S_RD1, 32'd0, "re1_off");

        // 3. r0 writes are dropped but still counted
        step();
        re1 = 1'b1;
        mem(5'd0, 1'b1, 32'h1234);
        raddr2 = 5'd0;
        expect_val(S_RD2, 32'd0, "r0_a");
        expect_val(S_CNT, 32'd1, "r0_cnt_a");
        step();
        mem_wreg = 1'b0;
        expect_wb(5'd0, 1'b1, 32'h1234, "r0_lat");
        expect_val(S_RD2, 32'd0, "r0_b");
        step();
        expect_val(S_RD2, 32'd0, "r0_c");
        expect_val(S_CNT, 32'd2, "r0_cnt_c");
        expect_val(S_RD1, 32'hDEADBEEF, "r3_keep");

        // 4a. MEM stalled, WB running: bubble, no commit
        step();
        mem(5'd5, 1'b1, 32'd7);
        stall = 6'b010000;
        raddr1 = 5'd5;
        step();
        expect_val(S_WREG, 32'd0, "bubble_wreg");
        expect_val(S_CNT, 32'd2, "bubble_cnt");
        // 4b. Load r5 write, then stall both stages: hold, no commit, no bypass
        stall = 6'b000000;
        step();
        stall = 6'b110000;
        expect_wb(5'd5, 1'b1, 32'd7, "hold_a");
        expect_val(S_RD1, 32'd0, "hold_no_bypass");
        step();
        expect_wb(5'd5, 1'b1, 32'd7, "hold_b");
        expect_val(S_CNT, 32'd2, "hold_cnt");
        expect_val(S_RD1, 32'd0, "hold_no_commit");
        // 4c. Release WB only: commit happens, latch becomes a bubble
        step();
        stall = 6'b010000;
        expect_val(S_RD1, 32'd7, "unstall_bypass");
        step();
        stall = 6'b000000;
        mem_wreg = 1'b0;
        expect_val(S_WREG, 32'd0, "unstall_wreg");
        expect_val(S_CNT, 32'd3, "unstall_cnt");
        expect_val(S_RD1, 32'd7, "unstall_array");

        // 5. Flush kills r8 write but the latched r9 write commits
        step();
        mem(5'd9, 1'b1, 32'h99);
        step();
        mem(5'd8, 1'b1, 32'h88);
        flush = 1'b1;
        expect_wb(5'd9, 1'b1, 32'h99, "flush_pre");
        step();
        flush = 1'b0;
        mem_wreg = 1'b0;
        raddr1 = 5'd9;
        raddr2 = 5'd8;
        expect_wb(5'd0, 1'b0, 32'd0, "flush_lat");
        expect_val(S_CNT, 32'd4, "flush_cnt");
        expect_val(S_RD1, 32'h99, "flush_r9");
        expect_val(S_RD2, 32'd0, "flush_r8");
        step();
        expect_val(S_RD2, 32'd0, "flush_r8_later");

        // 6. Counter wrap
        step();
        mem(5'd10, 1'b1, 32'hA5);
        force dut.retire_cnt_q = 32'hFFFFFFFF;
        #1;
        release dut.retire_cnt_q;
        expect_val(S_CNT, 32'hFFFFFFFF, "wrap_preload");
        step();
        mem_wreg = 1'b0;
        raddr1 = 5'd10;
        expect_val(S_CNT, 32'hFFFFFFFF, "wrap_hold");
        step();
        expect_val(S_CNT, 32'd0, "wrap_cnt");
        expect_val(S_RD1, 32'hA5, "wrap_r10");

        // 7. Reset during flush with a loaded latch: rst wins, array cleared
        mem(5'd11, 1'b1, 32'hBB);
        step();
        rst = 1'b1;
        flush = 1'b1;
        mem_wreg = 1'b0;
        expect_wb(5'd11, 1'b1, 32'hBB, "rstmid_pre");
        step();
        rst = 1'b0;
        flush = 1'b0;
        raddr2 = 5'd11;
        expect_wb(5'd0, 1'b0, 32'd0, "rstmid_lat");
        expect_val(S_CNT, 32'd0, "rstmid_cnt");
        expect_val(S_RD1, 32'd0, "rstmid_r10");
        expect_val(S_RD2, 32'd0, "rstmid_r11");

        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
